enc_ctrl_multi: RTL and testbench

Parametrised multi-channel quadrature encoder controller: per-channel input synchronisation and glitch filtering, 4x quadrature decoding into a configurable-width up/down counter with preload, sticky wrap and illegal-transition flags, and a fully synchronous index-pulse latch with optional zero-on-index and single-shot arming. It sits between the encoder connector pins and the main register file. It serves host reads through a channel-selected read mux and also exports all live counts to the on-board closed-loop controller.

---
 rtl/enc_ctrl_multi_if.sv | 23 ++
 rtl/enc_ctrl_multi.sv | 216 +++++++++++++++++++++
 tb/tb_enc_ctrl_multi.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enc_ctrl_multi_if.sv
// Host register bus for the quadrature encoder controller.
// master modport: the register file (drives the write strobe, address, data and read channel select).
// slave modport : enc_ctrl_multi (returns the channel-selected count, index, preload and control words).
interface enc_ctrl_multi_if;
    logic [3:0]  reg_raddr_chan;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [31:0] reg_count_data;
    logic [31:0] reg_index_data;
    logic [31:0] reg_preload;
    logic [31:0] reg_ctrl;

    modport master (
        output reg_raddr_chan, reg_waddr, reg_wdata, reg_wen,
        input  reg_count_data, reg_index_data, reg_preload, reg_ctrl
    );

    modport slave (
        input  reg_raddr_chan, reg_waddr, reg_wdata, reg_wen,
        output reg_count_data, reg_index_data, reg_preload, reg_ctrl
    );
endinterface

// File: rtl/enc_ctrl_multi.sv
// Multi-channel quadrature encoder controller.
// Each raw A/B/index line is synchronised (2 flops) and glitch filtered, the filtered
// A/B pair is 4x decoded into a modulo-2^CNT_W up/down counter with preload and sticky
// ovf/unf/err flags, and filtered index rising edges latch the count (optionally
// zeroing it to the preload value and optionally in single-shot mode).
// Ports:
//   sysclk        - single system clock
//   reset         - asynchronous active-low reset
//   enc_a/b/i     - raw encoder lines, one bit per channel, asynchronous
//   bus           - host register bus (slave side), channel-selected read mux
//   enc_count_all - live counts of all channels, channel 1 in the LSBs
module enc_ctrl_multi #(
    parameter int         NUM_CH    = 4,
    parameter int         CNT_W     = 24,
    parameter int         FILT_LEN  = 3,
    parameter logic [3:0] ADDR_MAIN = 4'h0,
    parameter logic [3:0] OFF_LOAD  = 4'h7,
    parameter logic [3:0] OFF_CTRL  = 4'h9
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic [NUM_CH-1:0]       enc_i,
    enc_ctrl_multi_if.slave         bus,
    output logic [NUM_CH*CNT_W-1:0] enc_count_all
);

    localparam int             NL        = 3 * NUM_CH;
    localparam logic [3:0]     FILT_LAST = 4'(FILT_LEN - 1);
    // Sync (2) + filter (FILT_LEN) settle before the first compare against a settled
    // previous state; the extra cycle covers the partial cycle in which reset releases.
    localparam logic [4:0]     BLANK_LEN = 5'(FILT_LEN + 3);
    localparam logic [CNT_W-1:0] CNT_MID  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Position of an (A,B) pair on the Gray cycle 00,01,11,10 -> 0,1,2,3.
    function automatic logic [1:0] gray_pos(input logic a, input logic b);
        return {a, a ^ b};
    endfunction

    // Lines are packed as {index, B, A}, NUM_CH bits each.
    logic [NL-1:0] w_raw;
    logic [NL-1:0] r_sync1, r_sync2, r_filt, r_prev;
    logic [3:0]    r_fcnt [NL];
    logic [4:0]    r_blank;
    logic          w_en;

    logic [CNT_W-1:0] r_count     [NUM_CH];
    logic [CNT_W-1:0] r_preload   [NUM_CH];
    logic [CNT_W-1:0] r_idx_count [NUM_CH];
    logic [3:0]       r_idx_cnt   [NUM_CH];
    logic [1:0]       r_ctrl      [NUM_CH];
    logic [NUM_CH-1:0] r_armed, r_ovf, r_unf, r_err, r_dir, r_seen, r_idx_dir;

    logic [NUM_CH-1:0] w_up, w_dn, w_bad, w_acc, w_ld, w_wc;
    logic              w_hit;
    logic [3:0]        w_wch, w_woff;
    logic              w_unused;

    assign w_raw    = {enc_i, enc_b, enc_a};
    assign w_en     = (r_blank == 5'd0);
    assign w_hit    = bus.reg_wen && (bus.reg_waddr[15:12] == ADDR_MAIN);
    assign w_wch    = bus.reg_waddr[7:4];
    assign w_woff   = bus.reg_waddr[3:0];
    assign w_unused = ^{bus.reg_waddr[11:8], bus.reg_wdata[31:CNT_W]};

    // Synchroniser and stability filter for every raw line.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= {NL{1'b0}};
            r_sync2 <= {NL{1'b0}};
            r_filt  <= {NL{1'b0}};
            for (int l = 0; l < NL; l++) r_fcnt[l] <= 4'd0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int l = 0; l < NL; l++) begin
                if (r_sync2[l] != r_filt[l]) begin
                    if (r_fcnt[l] == FILT_LAST) begin
                        r_filt[l] <= r_sync2[l];
                        r_fcnt[l] <= 4'd0;
                    end else begin
                        r_fcnt[l] <= r_fcnt[l] + 4'd1;
                    end
                end else begin
                    r_fcnt[l] <= 4'd0;
                end
            end
        end
    end

    // Previous filtered state (always tracking) and post-reset blanking counter.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_prev  <= {NL{1'b0}};
            r_blank <= BLANK_LEN;
        end else begin
            r_prev <= r_filt;
            if (r_blank != 5'd0) r_blank <= r_blank - 5'd1;
        end
    end

    // Per-channel step/index decode and register write decode.
    always_comb begin
        w_up  = {NUM_CH{1'b0}};
        w_dn  = {NUM_CH{1'b0}};
        w_bad = {NUM_CH{1'b0}};
        w_acc = {NUM_CH{1'b0}};
        w_ld  = {NUM_CH{1'b0}};
        w_wc  = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            logic [1:0] w_delta;
            w_delta = gray_pos(r_filt[c], r_filt[NUM_CH+c]) - gray_pos(r_prev[c], r_prev[NUM_CH+c]);
            w_up[c]  = w_en && (w_delta == 2'd1);
            w_dn[c]  = w_en && (w_delta == 2'd3);
            w_bad[c] = w_en && (w_delta == 2'd2);
            w_acc[c] = w_en && r_filt[2*NUM_CH+c] && !r_prev[2*NUM_CH+c]
                       && (!r_ctrl[c][1] || r_armed[c]);
            w_ld[c]  = w_hit && (w_woff == OFF_LOAD) && (w_wch == 4'(c + 1));
            w_wc[c]  = w_hit && (w_woff == OFF_CTRL) && (w_wch == 4'(c + 1));
        end
    end

    // Counter, flags, control and index latch per channel.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_armed   <= {NUM_CH{1'b0}};
            r_ovf     <= {NUM_CH{1'b0}};
            r_unf     <= {NUM_CH{1'b0}};
            r_err     <= {NUM_CH{1'b0}};
            r_dir     <= {NUM_CH{1'b0}};
            r_seen    <= {NUM_CH{1'b0}};
            r_idx_dir <= {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                r_count[c]     <= CNT_MID;
                r_preload[c]   <= CNT_MID;
                r_idx_count[c] <= CNT_ZERO;
                r_idx_cnt[c]   <= 4'd0;
                r_ctrl[c]      <= 2'd0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // Counter priority: preload write, then zero-on-index, then quadrature step.
                if (w_ld[c]) begin
                    r_count[c]   <= bus.reg_wdata[CNT_W-1:0];
                    r_preload[c] <= bus.reg_wdata[CNT_W-1:0];
                    r_ovf[c]     <= 1'b0;
                    r_unf[c]     <= 1'b0;
                    r_err[c]     <= 1'b0;
                end else begin
                    if (w_acc[c] && r_ctrl[c][0]) begin
                        r_count[c] <= r_preload[c];
                    end else if (w_up[c]) begin
                        r_count[c] <= r_count[c] + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (r_count[c] == CNT_ONES) r_ovf[c] <= 1'b1;
                    end else if (w_dn[c]) begin
                        r_count[c] <= r_count[c] - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (r_count[c] == CNT_ZERO) r_unf[c] <= 1'b1;
                    end
                    if (w_bad[c]) r_err[c] <= 1'b1;
                end

                if (w_up[c])      r_dir[c] <= 1'b1;
                else if (w_dn[c]) r_dir[c] <= 1'b0;

                // Single-shot arming: set by a ctrl write with single=1, consumed by a latch.
                if (w_wc[c]) begin
                    r_ctrl[c]  <= bus.reg_wdata[1:0];
                    r_armed[c] <= bus.reg_wdata[1];
                end else if (!r_ctrl[c][1] || w_acc[c]) begin
                    r_armed[c] <= 1'b0;
                end

                if (w_wc[c] && bus.reg_wdata[2]) begin
                    r_idx_cnt[c]   <= 4'd0;
                    r_seen[c]      <= 1'b0;
                    r_idx_count[c] <= CNT_ZERO;
                    r_idx_dir[c]   <= 1'b0;
                end else if (w_acc[c]) begin
                    r_idx_cnt[c]   <= r_idx_cnt[c] + 4'd1;
                    r_seen[c]      <= 1'b1;
                    r_idx_count[c] <= r_count[c];
                    r_idx_dir[c]   <= r_dir[c];
                end
            end
        end
    end

    // Host read mux; an out-of-range channel select reads as zero.
    always_comb begin
        bus.reg_count_data = 32'd0;
        bus.reg_index_data = 32'd0;
        bus.reg_preload    = 32'd0;
        bus.reg_ctrl       = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.reg_raddr_chan == 4'(c + 1)) begin
                bus.reg_count_data = {r_ovf[c], r_unf[c], r_err[c], {(29-CNT_W){1'b0}}, r_count[c]};
                bus.reg_index_data = 32'(r_idx_count[c]) | (32'(r_idx_dir[c]) << CNT_W)
                                   | {r_idx_cnt[c], r_seen[c], r_armed[c], 26'd0};
                bus.reg_preload    = 32'(r_preload[c]);
                bus.reg_ctrl       = {30'd0, r_ctrl[c]};
            end else begin
                bus.reg_count_data = bus.reg_count_data;
            end
        end
    end

    // Live counts straight from the count registers.
    always_comb begin
        enc_count_all = {(NUM_CH*CNT_W){1'b0}};
        for (int c = 0; c < NUM_CH; c++) enc_count_all[c*CNT_W +: CNT_W] = r_count[c];
    end

endmodule

// File: tb/tb_enc_ctrl_multi.sv
// Self-checking bench for enc_ctrl_multi (NUM_CH=4, CNT_W=24, FILT_LEN=3).
// The reference model tracks each channel as a Gray-cycle position plus an integer
// count, flags and index-latch fields, updated from the behavioural rules.
module tb_enc_ctrl_multi;
    localparam int NCH = 4;
    localparam int CW  = 24;
    localparam int FL  = 3;

    logic          sysclk = 1'b0;
    logic          reset  = 1'b0;
    logic [NCH-1:0] enc_a, enc_b, enc_i;
    logic [NCH*CW-1:0] enc_count_all;

    enc_ctrl_multi_if bus ();

    enc_ctrl_multi #(.NUM_CH(NCH), .CNT_W(CW), .FILT_LEN(FL)) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .enc_a         (enc_a),
        .enc_b         (enc_b),
        .enc_i         (enc_i),
        .bus           (bus),
        .enc_count_all (enc_count_all)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [1:0]    gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [CW-1:0] m_count [NCH], m_preload [NCH], m_idx_count [NCH];
    logic [3:0]    m_idx_cnt [NCH];
    bit            m_ovf [NCH], m_unf [NCH], m_err [NCH], m_dir [NCH], m_seen [NCH];
    bit            m_idx_dir [NCH], m_zero [NCH], m_single [NCH], m_armed [NCH];
    int            m_pos [NCH];

    function automatic logic [31:0] exp_count(input int ch);
        return {m_ovf[ch], m_unf[ch], m_err[ch], 5'b0, m_count[ch]};
    endfunction

    function automatic logic [31:0] exp_index(input int ch);
        return {m_idx_cnt[ch], m_seen[ch], m_armed[ch], 1'b0, m_idx_dir[ch], m_idx_count[ch]};
    endfunction

    function automatic logic [NCH*CW-1:0] exp_all();
        logic [NCH*CW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*CW +: CW] = m_count[c];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic drive_pos(input int ch);
        {enc_a[ch], enc_b[ch]} = gray_tab[m_pos[ch]];
    endtask

    task automatic model_step(input int ch, input bit up);
        if (up) begin
            if (m_count[ch] == 24'hFFFFFF) m_ovf[ch] = 1'b1;
            m_count[ch] = m_count[ch] + 24'd1;
            m_pos[ch]   = (m_pos[ch] + 1) % 4;
        end else begin
            if (m_count[ch] == 24'h000000) m_unf[ch] = 1'b1;
            m_count[ch] = m_count[ch] - 24'd1;
            m_pos[ch]   = (m_pos[ch] + 3) % 4;
        end
        m_dir[ch] = up;
    endtask

    task automatic model_load(input int ch, input logic [CW-1:0] v);
        m_count[ch] = v;  m_preload[ch] = v;
        m_ovf[ch] = 1'b0; m_unf[ch] = 1'b0; m_err[ch] = 1'b0;
    endtask

    task automatic model_ctrl(input int ch, input logic [2:0] v);
        m_zero[ch] = v[0]; m_single[ch] = v[1]; m_armed[ch] = v[1];
        if (v[2]) begin
            m_idx_cnt[ch] = 4'd0; m_seen[ch] = 1'b0; m_idx_count[ch] = 24'd0; m_idx_dir[ch] = 1'b0;
        end
    endtask

    task automatic model_index(input int ch);
        if (!m_single[ch] || m_armed[ch]) begin
            m_idx_count[ch] = m_count[ch];
            m_idx_dir[ch]   = m_dir[ch];
            m_idx_cnt[ch]   = m_idx_cnt[ch] + 4'd1;
            m_seen[ch]      = 1'b1;
            if (m_zero[ch]) m_count[ch] = m_preload[ch];
            m_armed[ch] = 1'b0;
        end
    endtask

    task automatic step(input int ch, input bit up, input int hold);
        model_step(ch, up);
        drive_pos(ch);
        tick(hold);
    endtask

    task automatic bus_write(input logic [3:0] ch, input logic [3:0] off, input logic [31:0] d);
        bus.reg_waddr = {4'h0, 4'h0, ch, off};
        bus.reg_wdata = d;
        bus.reg_wen   = 1'b1;
        tick(1);
        bus.reg_wen   = 1'b0;
    endtask

    task automatic pulse_index(input int ch);
        enc_i[ch] = 1'b1;
        model_index(ch);
        tick(10);
        enc_i[ch] = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        enc_a = 4'hF; enc_b = 4'hF; enc_i = 4'h0;
        bus.reg_wen = 1'b0; bus.reg_waddr = 16'h0; bus.reg_wdata = 32'h0; bus.reg_raddr_chan = 4'd1;
        for (int c = 0; c < NCH; c++) begin
            m_pos[c] = 2; m_count[c] = 24'h800000; m_preload[c] = 24'h800000;
            m_idx_count[c] = 24'd0; m_idx_cnt[c] = 4'd0;
            m_ovf[c] = 0; m_unf[c] = 0; m_err[c] = 0; m_dir[c] = 0; m_seen[c] = 0;
            m_idx_dir[c] = 0; m_zero[c] = 0; m_single[c] = 0; m_armed[c] = 0;
        end
        tick(3);
        if (bus.reg_count_data !== 32'h00800000) begin n_fail++; $display("FAIL rst_count: got %h want %h", bus.reg_count_data, 32'h00800000); end
        n_cmp++;
        if (bus.reg_preload !== 32'h00800000) begin n_fail++; $display("FAIL rst_preload: got %h want %h", bus.reg_preload, 32'h00800000); end
        n_cmp++;
        if (bus.reg_index_data !== 32'h0 || bus.reg_ctrl !== 32'h0) begin n_fail++; $display("FAIL rst_index_ctrl: got %h/%h want 0/0", bus.reg_index_data, bus.reg_ctrl); end
        n_cmp++;
        reset = 1'b1;
        tick(20);
        for (int c = 0; c < NCH; c++) begin
            bus.reg_raddr_chan = 4'(c + 1); #1;
            if (bus.reg_count_data !== exp_count(c)) begin n_fail++; $display("FAIL rst_lines_high ch%0d: got %h want %h", c + 1, bus.reg_count_data, exp_count(c)); end
            n_cmp++;
        end
        if (enc_count_all !== exp_all()) begin n_fail++; $display("FAIL rst_count_all: got %h want %h", enc_count_all, exp_all()); end
        n_cmp++;
        bus.reg_raddr_chan = 4'd0; #1;
        if (bus.reg_count_data !== 32'h0 || bus.reg_preload !== 32'h0) begin n_fail++; $display("FAIL sel0: got %h/%h want 0/0", bus.reg_count_data, bus.reg_preload); end
        n_cmp++;
        bus.reg_raddr_chan = 4'd5; #1;
        if (bus.reg_count_data !== 32'h0 || bus.reg_preload !== 32'h0) begin n_fail++; $display("FAIL sel5: got %h/%h want 0/0", bus.reg_count_data, bus.reg_preload); end
        n_cmp++;
    endtask

    task automatic test_gray();
        logic [31:0] old_v;
        bus.reg_raddr_chan = 4'd2;
        tick(1);
        old_v = exp_count(1);
        model_step(1, 1'b1);
        drive_pos(1);
        tick(FL + 2);
        if (bus.reg_count_data !== old_v) begin n_fail++; $display("FAIL lat_early: got %h want %h", bus.reg_count_data, old_v); end
        n_cmp++;
        tick(1);
        if (bus.reg_count_data !== exp_count(1)) begin n_fail++; $display("FAIL lat_edge: got %h want %h", bus.reg_count_data, exp_count(1)); end
        n_cmp++;
        tick(7);
        for (int s = 0; s < 3; s++) step(1, 1'b1, 10);
        if (bus.reg_count_data !== exp_count(1)) begin n_fail++; $display("FAIL fwd4: got %h want %h", bus.reg_count_data, exp_count(1)); end
        n_cmp++;
        pulse_index(1);
        if (bus.reg_index_data !== exp_index(1)) begin n_fail++; $display("FAIL idx_fwd: got %h want %h", bus.reg_index_data, exp_index(1)); end
        n_cmp++;
        for (int s = 0; s < 4; s++) step(1, 1'b0, 10);
        if (bus.reg_count_data !== exp_count(1)) begin n_fail++; $display("FAIL rev4: got %h want %h", bus.reg_count_data, exp_count(1)); end
        n_cmp++;
        pulse_index(1);
        if (bus.reg_index_data !== exp_index(1)) begin n_fail++; $display("FAIL idx_rev: got %h want %h", bus.reg_index_data, exp_index(1)); end
        n_cmp++;
    endtask

    task automatic test_wrap();
        bus.reg_raddr_chan = 4'd1;
        bus_write(4'd1, 4'h7, 32'h00FFFFFF); model_load(0, 24'hFFFFFF);
        if (bus.reg_preload !== 32'h00FFFFFF) begin n_fail++; $display("FAIL preload_rd: got %h want %h", bus.reg_preload, 32'h00FFFFFF); end
        n_cmp++;
        step(0, 1'b1, 10);
        if (bus.reg_count_data !== exp_count(0)) begin n_fail++; $display("FAIL ovf: got %h want %h", bus.reg_count_data, exp_count(0)); end
        n_cmp++;
        bus_write(4'd1, 4'h7, 32'h00FFFFFF); model_load(0, 24'hFFFFFF);
        if (bus.reg_count_data !== exp_count(0)) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", bus.reg_count_data, exp_count(0)); end
        n_cmp++;
        bus_write(4'd1, 4'h7, 32'h0); model_load(0, 24'h0);
        step(0, 1'b0, 10);
        if (bus.reg_count_data !== exp_count(0)) begin n_fail++; $display("FAIL unf: got %h want %h", bus.reg_count_data, exp_count(0)); end
        n_cmp++;
        enc_a[0] = ~enc_a[0];
        tick(2);
        enc_a[0] = ~enc_a[0];
        tick(12);
        if (bus.reg_count_data !== exp_count(0)) begin n_fail++; $display("FAIL glitch: got %h want %h", bus.reg_count_data, exp_count(0)); end
        n_cmp++;
    endtask

    task automatic test_illegal();
        bus.reg_raddr_chan = 4'd3;
        m_pos[2] = (m_pos[2] + 2) % 4;
        m_err[2] = 1'b1;
        drive_pos(2);
        tick(10);
        if (bus.reg_count_data !== exp_count(2)) begin n_fail++; $display("FAIL illegal: got %h want %h", bus.reg_count_data, exp_count(2)); end
        n_cmp++;
    endtask

    task automatic test_index_single();
        bus.reg_raddr_chan = 4'd4;
        bus_write(4'd4, 4'h7, 32'h00000100); model_load(3, 24'h000100);
        for (int s = 0; s < 4; s++) step(3, 1'b1, 10);
        bus_write(4'd4, 4'h9, 32'h3); model_ctrl(3, 3'd3);
        if (bus.reg_ctrl !== 32'h3 || bus.reg_index_data !== exp_index(3)) begin n_fail++; $display("FAIL arm: got %h/%h want %h/%h", bus.reg_ctrl, bus.reg_index_data, 32'h3, exp_index(3)); end
        n_cmp++;
        pulse_index(3);
        if (bus.reg_count_data !== exp_count(3) || bus.reg_index_data !== exp_index(3)) begin n_fail++; $display("FAIL single1: got %h/%h want %h/%h", bus.reg_count_data, bus.reg_index_data, exp_count(3), exp_index(3)); end
        n_cmp++;
        step(3, 1'b1, 10);
        pulse_index(3);
        if (bus.reg_count_data !== exp_count(3) || bus.reg_index_data !== exp_index(3)) begin n_fail++; $display("FAIL single2: got %h/%h want %h/%h", bus.reg_count_data, bus.reg_index_data, exp_count(3), exp_index(3)); end
        n_cmp++;
        bus_write(4'd4, 4'h9, 32'h4); model_ctrl(3, 3'd4);
        if (bus.reg_ctrl !== 32'h0 || bus.reg_index_data !== exp_index(3)) begin n_fail++; $display("FAIL idx_clr: got %h/%h want %h/%h", bus.reg_ctrl, bus.reg_index_data, 32'h0, exp_index(3)); end
        n_cmp++;
    endtask

    task automatic test_coincident();
        logic [CW-1:0] w_val;
        w_val = 24'($urandom);
        bus.reg_raddr_chan = 4'd1;
        bus_write(4'd1, 4'h9, 32'h1); model_ctrl(0, 3'd1);
        model_index(0);
        model_step(0, 1'b1);
        model_load(0, w_val);
        drive_pos(0);
        enc_i[0] = 1'b1;
        tick(FL + 2);
        bus.reg_waddr = 16'h0017; bus.reg_wdata = 32'(w_val); bus.reg_wen = 1'b1;
        tick(1);
        bus.reg_wen = 1'b0;
        if (bus.reg_count_data !== exp_count(0)) begin n_fail++; $display("FAIL coinc_count: got %h want %h", bus.reg_count_data, exp_count(0)); end
        n_cmp++;
        if (bus.reg_index_data !== exp_index(0)) begin n_fail++; $display("FAIL coinc_index: got %h want %h", bus.reg_index_data, exp_index(0)); end
        n_cmp++;
        enc_i[0] = 1'b0;
        tick(10);
        bus_write(4'd0, 4'h7, $urandom);
        bus_write(4'd5, 4'h7, $urandom);
        tick(2);
        for (int c = 0; c < NCH; c++) begin
            bus.reg_raddr_chan = 4'(c + 1); #1;
            if (bus.reg_count_data !== exp_count(c) || bus.reg_preload !== 32'(m_preload[c])) begin
                n_fail++; $display("FAIL bad_chan_write ch%0d: got %h/%h want %h/%h", c + 1, bus.reg_count_data, bus.reg_preload, exp_count(c), 32'(m_preload[c]));
            end
            n_cmp++;
        end
    endtask

    task automatic test_random_walk();
        for (int it = 0; it < 40; it++) begin
            int ch;
            ch = int'($urandom_range(0, NCH - 1));
            bus.reg_raddr_chan = 4'(ch + 1);
            step(ch, 1'($urandom_range(0, 1)), int'($urandom_range(7, 11)));
            if (bus.reg_count_data !== exp_count(ch)) begin n_fail++; $display("FAIL walk%0d ch%0d: got %h want %h", it, ch + 1, bus.reg_count_data, exp_count(ch)); end
            n_cmp++;
            if (enc_count_all !== exp_all()) begin n_fail++; $display("FAIL walk_all%0d: got %h want %h", it, enc_count_all, exp_all()); end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_gray();
        test_wrap();
        test_illegal();
        test_index_single();
        test_coincident();
        test_random_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
